// File: rtl/lt_timer_bank.sv
// Multi-channel timeout/interval timer bank on a single sb_clk domain.
// A shared prescaler feeds the per-channel timebase; each channel reports expiry level and pulse.
module lt_timer_bank #(
    parameter int unsigned NUM_CH     = 7,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PRESCALE_W = 8,
    parameter int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    sb_clk,
    input  logic                    rst,
    input  logic [PRESCALE_W-1:0]   prescale,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       ch_clr,
    input  logic [NUM_CH-1:0]       ch_periodic,
    input  logic [NUM_CH-1:0]       ch_use_tick,
    input  logic [NUM_CH*CNT_W-1:0] ch_limit,
    input  logic [SEL_W-1:0]        cnt_sel,
    output logic                    tick,
    output logic [NUM_CH-1:0]       expired,
    output logic [NUM_CH-1:0]       expired_pulse,
    output logic [CNT_W-1:0]        cnt_rd
);

    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  lim   [NUM_CH];
    logic [CNT_W:0]    cnt_inc [NUM_CH];
    logic [NUM_CH-1:0] adv;
    logic [NUM_CH-1:0] exp_q, exp_d;
    logic [NUM_CH-1:0] pulse_q, pulse_d;
    logic [CNT_W-1:0]  cnt_rd_q, cnt_rd_d;

    // >= rather than == so a lowered prescale ticks next cycle instead of wrapping through.
    always_comb begin
        tick      = (pre_cnt_q >= prescale);
        pre_cnt_d = tick ? '0 : pre_cnt_q + PRESCALE_W'(1);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign lim[g]     = ch_limit[g*CNT_W +: CNT_W];
        assign adv[g]     = ch_use_tick[g] ? tick : 1'b1;
        // One extra bit so cnt+1 never wraps before the compare.
        assign cnt_inc[g] = {1'b0, cnt_q[g]} + (CNT_W+1)'(1);
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]   = cnt_q[i];
            exp_d[i]   = exp_q[i];
            pulse_d[i] = 1'b0;
            if (!ch_en[i] || ch_clr[i]) begin
                cnt_d[i] = '0;
                exp_d[i] = 1'b0;
            end else if (!ch_periodic[i] && exp_q[i]) begin
                exp_d[i] = 1'b1;
            end else if (lim[i] == '0) begin
                cnt_d[i]   = '0;
                exp_d[i]   = 1'b1;
                pulse_d[i] = 1'b1;
            end else if (adv[i]) begin
                if (cnt_inc[i] >= {1'b0, lim[i]}) begin
                    cnt_d[i]   = ch_periodic[i] ? '0 : lim[i];
                    exp_d[i]   = 1'b1;
                    pulse_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_inc[i][CNT_W-1:0];
                end
            end
        end
    end

    // Out-of-range selects match no channel and read back 0.
    always_comb begin
        cnt_rd_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cnt_sel == SEL_W'(i)) begin
                cnt_rd_d = cnt_q[i];
            end
        end
    end

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            pre_cnt_q <= '0;
            exp_q     <= '0;
            pulse_q   <= '0;
            cnt_rd_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pre_cnt_q <= pre_cnt_d;
            exp_q     <= exp_d;
            pulse_q   <= pulse_d;
            cnt_rd_q  <= cnt_rd_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign expired       = exp_q;
    assign expired_pulse = pulse_q;
    assign cnt_rd        = cnt_rd_q;

endmodule

// File: tb/tb_lt_timer_bank.sv
// Directed bench for lt_timer_bank: expected values are queued as stimulus is applied
// and popped in order as the DUT outputs are sampled 1 time unit after each rising edge.
module tb_lt_timer_bank;

    localparam int NUM_CH     = 7;
    localparam int CNT_W      = 16;
    localparam int PRESCALE_W = 8;
    localparam int SEL_W      = 3;

    logic                    sb_clk;
    logic                    rst;
    logic [PRESCALE_W-1:0]   prescale;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       ch_clr;
    logic [NUM_CH-1:0]       ch_periodic;
    logic [NUM_CH-1:0]       ch_use_tick;
    logic [NUM_CH*CNT_W-1:0] ch_limit;
    logic [SEL_W-1:0]        cnt_sel;
    logic                    tick;
    logic [NUM_CH-1:0]       expired;
    logic [NUM_CH-1:0]       expired_pulse;
    logic [CNT_W-1:0]        cnt_rd;

    lt_timer_bank #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .PRESCALE_W (PRESCALE_W),
        .SEL_W      (SEL_W)
    ) dut (
        .sb_clk        (sb_clk),
        .rst           (rst),
        .prescale      (prescale),
        .ch_en         (ch_en),
        .ch_clr        (ch_clr),
        .ch_periodic   (ch_periodic),
        .ch_use_tick   (ch_use_tick),
        .ch_limit      (ch_limit),
        .cnt_sel       (cnt_sel),
        .tick          (tick),
        .expired       (expired),
        .expired_pulse (expired_pulse),
        .cnt_rd        (cnt_rd)
    );

    initial sb_clk = 1'b0;
    always #5 sb_clk = ~sb_clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed %0h, required a queued expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h, required %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sb_clk);
        #1;
    endtask

    task automatic set_lim(input int ch, input logic [CNT_W-1:0] v);
        ch_limit[ch*CNT_W +: CNT_W] = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b0;
        prescale    = '0;
        ch_en       = '0;
        ch_clr      = '0;
        ch_periodic = '0;
        ch_use_tick = '0;
        ch_limit    = '0;
        cnt_sel     = '0;
        #3;
        push("rst_expired", 0);
        push("rst_pulse", 0);
        push("rst_cnt_rd", 0);
        push("rst_tick_ps0", 1);
        chk(32'(expired));
        chk(32'(expired_pulse));
        chk(32'(cnt_rd));
        chk(32'(tick));
        step(2);
        rst = 1'b1;

        // One-shot, every-cycle timebase, limit 14
        set_lim(0, 14);
        cnt_sel  = 0;
        ch_en[0] = 1'b1;
        push("t1_exp_c13", 0);
        push("t1_exp_c14", 1);
        push("t1_pulse_c14", 1);
        push("t1_pulse_c15", 0);
        push("t1_exp_c15", 1);
        push("t1_cnt_rd_c15", 14);
        step(13);
        chk(32'(expired[0]));
        step(1);
        chk(32'(expired[0]));
        chk(32'(expired_pulse[0]));
        step(1);
        chk(32'(expired_pulse[0]));
        chk(32'(expired[0]));
        chk(32'(cnt_rd));
        ch_en[0] = 1'b0;

        // Periodic on prescaled tick: prescale 4, limit 3
        prescale       = 4;
        ch_periodic[1] = 1'b1;
        ch_use_tick[1] = 1'b1;
        set_lim(1, 3);
        cnt_sel  = 1;
        ch_en[1] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            push("t2_pulse", 32'((c == 15) || (c == 30)));
            push("t2_tick", 32'(c % 5 == 4));
            if (c == 6)  push("t2_cnt_rd_1", 1);
            if (c == 11) push("t2_cnt_rd_2", 2);
            if (c == 16) push("t2_cnt_rd_0", 0);
            if (c == 14) push("t2_exp_before", 0);
            if (c == 16) push("t2_exp_sticky", 1);
            if (c == 29) push("t2_exp_sticky_late", 1);
        end
        for (int c = 1; c <= 30; c++) begin
            step(1);
            chk(32'(expired_pulse[1]));
            chk(32'(tick));
            if (c == 6 || c == 11 || c == 16) chk(32'(cnt_rd));
            if (c == 14 || c == 16 || c == 29) chk(32'(expired[1]));
        end
        ch_en[1] = 1'b0;
        prescale = 0;

        // Clear coincident with expiry on a one-shot channel
        set_lim(2, 10);
        cnt_sel  = 2;
        ch_en[2] = 1'b1;
        push("t3_exp_at_clr", 0);
        push("t3_pulse_at_clr", 0);
        push("t3_cnt_after_clr", 0);
        push("t3_exp_c9_after", 0);
        push("t3_exp_c10_after", 1);
        push("t3_pulse_c10_after", 1);
        step(9);
        ch_clr[2] = 1'b1;
        step(1);
        chk(32'(expired[2]));
        chk(32'(expired_pulse[2]));
        ch_clr[2] = 1'b0;
        step(1);
        chk(32'(cnt_rd));
        step(8);
        chk(32'(expired[2]));
        step(1);
        chk(32'(expired[2]));
        chk(32'(expired_pulse[2]));
        ch_en[2] = 1'b0;

        // Run-time limit decrease below the live count, then disable
        set_lim(3, 500);
        cnt_sel  = 3;
        ch_en[3] = 1'b1;
        step(200);
        set_lim(3, 100);
        push("t4_exp_after_drop", 1);
        push("t4_pulse_after_drop", 1);
        push("t4_cnt_rd_200", 200);
        push("t4_exp_disabled", 0);
        push("t4_pulse_disabled", 0);
        push("t4_cnt_rd_disabled", 0);
        step(1);
        chk(32'(expired[3]));
        chk(32'(expired_pulse[3]));
        chk(32'(cnt_rd));
        ch_en[3] = 1'b0;
        step(1);
        chk(32'(expired[3]));
        chk(32'(expired_pulse[3]));
        step(1);
        chk(32'(cnt_rd));

        // Asynchronous reset mid-count with prescale 7
        prescale = 7;
        set_lim(4, 1000);
        cnt_sel  = 4;
        ch_en[4] = 1'b1;
        step(20);
        rst = 1'b0;
        #2;
        push("t5_rst_expired", 0);
        push("t5_rst_pulse", 0);
        push("t5_rst_cnt_rd", 0);
        push("t5_rst_tick", 0);
        chk(32'(expired));
        chk(32'(expired_pulse));
        chk(32'(cnt_rd));
        chk(32'(tick));
        @(negedge sb_clk);
        rst = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            push("t5_tick", 32'(c == 7));
            if (c == 3) push("t5_cnt_restart", 2);
        end
        for (int c = 1; c <= 9; c++) begin
            step(1);
            chk(32'(tick));
            if (c == 3) chk(32'(cnt_rd));
        end
        ch_en[4] = 1'b0;
        prescale = 0;
        step(1);

        // All channels limit 25 enabled together, then a limit-0 periodic channel
        for (int i = 0; i < NUM_CH; i++) set_lim(i, 25);
        ch_periodic = '0;
        ch_use_tick = '0;
        ch_en       = '1;
        push("t6_pulse_c24", 0);
        push("t6_pulse_c25", 7'h7f);
        push("t6_exp_c25", 7'h7f);
        push("t6_pulse_c26", 0);
        push("t6_exp_c26", 7'h7f);
        step(24);
        chk(32'(expired_pulse));
        step(1);
        chk(32'(expired_pulse));
        chk(32'(expired));
        step(1);
        chk(32'(expired_pulse));
        chk(32'(expired));

        cnt_sel = 6;
        push("t6_cnt_rd_held", 25);
        step(2);
        chk(32'(cnt_rd));
        cnt_sel = 7;
        push("t6_cnt_rd_oor", 0);
        step(1);
        chk(32'(cnt_rd));

        ch_periodic[5] = 1'b1;
        set_lim(5, 0);
        for (int c = 0; c < 4; c++) push("t6_lim0_pulse", 7'h20);
        for (int c = 0; c < 4; c++) begin
            step(1);
            chk(32'(expired_pulse));
        end

        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d left, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
